// File: rtl/axi_transmit_arbiter.sv
// axi_transmit_arbiter: round-robin owner selection for one shared transmit
// serializer. Each grant captures one word, fires a one-cycle tx_send, then
// waits for tx_done (or a timeout) and reports back to the owning requester.
module axi_transmit_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int DATA_WIDTH     = 32,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          halt,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            req_err,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_send,
  input  logic                          tx_done,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  // Counter holds 0..TIMEOUT_CYCLES-1; keep at least one bit when timeout is tiny/off.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state;
  logic [ID_W-1:0]  last_grant;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  scan_idx;
  logic [ID_W-1:0]  win;
  logic             found;

  // Winner search: first valid requester after last_grant, wrapping, so a
  // requester with valid low is skipped in the same cycle.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  // Grant/wait sequencer; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      cnt        <= '0;
      tx_data    <= '0;
      tx_send    <= 1'b0;
      req_ready  <= '0;
      req_done   <= '0;
      req_err    <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
    end else begin
      tx_send   <= 1'b0;
      req_ready <= '0;
      req_done  <= '0;
      req_err   <= '0;
      case (state)
        IDLE: begin
          // tx_done arriving here is stray and deliberately ignored.
          if (!halt && found) begin
            tx_data   <= req_data[win*DATA_WIDTH +: DATA_WIDTH];
            grant_id  <= win;
            tx_send   <= 1'b1;
            req_ready <= NUM_REQ'(1) << win;
            busy      <= 1'b1;
            cnt       <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // tx_send is high only in the launch cycle; tx_done there is ignored.
          if (tx_send) begin
            cnt <= '0;
          end else if (tx_done) begin
            // Success wins over a timeout landing in the same cycle.
            req_done[grant_id] <= 1'b1;
            busy               <= 1'b0;
            last_grant         <= grant_id;
            state              <= IDLE;
          end else if (TIMEOUT_CYCLES != 0 && cnt == TO_LAST) begin
            req_err[grant_id] <= 1'b1;
            busy              <= 1'b0;
            last_grant        <= grant_id;
            state             <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
